// File: rtl/eth_frame_gen.sv
// Ethernet II frame generator: preamble, SFD, fixed header, seeded pattern payload padded to 46 bytes, FCS, inter-frame gap.
// Latency: a start accepted at edge N puts the first preamble byte on gmii_txd after edge N+1. All outputs are registered.
// Backpressure: none. A start that arrives while busy is dropped, not queued.
module eth_frame_gen #(
    parameter logic [47:0] DST_MAC   = 48'hFF_FF_FF_FF_FF_FF,
    parameter logic [47:0] SRC_MAC   = 48'h00_0A_35_01_02_03,
    parameter logic [15:0] ETH_TYPE  = 16'h88B5,
    parameter int          IFG_BYTES = 12,
    parameter int          MAX_LEN   = 1500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [10:0] payload_len,
    input  logic [7:0]  payload_seed,
    output logic        busy,
    output logic        done,
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_en,
    output logic        gmii_tx_er,
    output logic [15:0] frame_cnt
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_SFD  = 3'd2;
    localparam logic [2:0] S_HDR  = 3'd3;
    localparam logic [2:0] S_PAY  = 3'd4;
    localparam logic [2:0] S_FCS  = 3'd5;
    localparam logic [2:0] S_IFG  = 3'd6;

    localparam logic [10:0]  MAX_L    = 11'(MAX_LEN);
    localparam logic [10:0]  MIN_L    = 11'd46;
    localparam logic [10:0]  IFG_LAST = 11'(IFG_BYTES - 1);
    localparam logic [111:0] HDR      = {DST_MAC, SRC_MAC, ETH_TYPE};

    logic [2:0]  state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [10:0] len_q, len_d;        // effective frame payload length (after pad/clamp)
    logic [10:0] pat_q, pat_d;        // number of pattern bytes before zero padding
    logic [7:0]  seed_q, seed_d;
    logic [31:0] crc_q, crc_d;
    logic [7:0]  txd_q, txd_d;
    logic        tx_en_q, tx_en_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    logic [7:0]  cur_byte;
    logic [10:0] clamp_len;
    logic        last;

    // Reflected CRC-32, one byte per call, LSB first.
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    // Next-state, byte selection, CRC update and registered-output values.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        pat_d       = pat_q;
        seed_d      = seed_q;
        crc_d       = crc_q;
        cur_byte    = 8'h00;
        tx_en_d     = 1'b0;
        done_d      = 1'b0;
        last        = 1'b0;
        clamp_len   = (payload_len > MAX_L) ? MAX_L : payload_len;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_PRE;
                    cnt_d   = 11'd0;
                    pat_d   = clamp_len;
                    len_d   = (clamp_len < MIN_L) ? MIN_L : clamp_len;
                    seed_d  = payload_seed;
                end
            end
            S_PRE: begin
                cur_byte = 8'h55;
                tx_en_d  = 1'b1;
                last     = (cnt_q == 11'd6);
            end
            S_SFD: begin
                cur_byte = 8'hD5;
                tx_en_d  = 1'b1;
                crc_d    = 32'hFFFF_FFFF;
                last     = 1'b1;
            end
            S_HDR: begin
                cur_byte = 8'(HDR >> (7'd104 - {cnt_q[3:0], 3'b000}));
                tx_en_d  = 1'b1;
                crc_d    = crc_step(crc_q, cur_byte);
                last     = (cnt_q == 11'd13);
            end
            S_PAY: begin
                cur_byte = (cnt_q < pat_q) ? (seed_q + cnt_q[7:0]) : 8'h00;
                tx_en_d  = 1'b1;
                crc_d    = crc_step(crc_q, cur_byte);
                last     = (cnt_q == 11'(len_q - 11'd1));
            end
            S_FCS: begin
                // crc_q is frozen here; the FCS is its inverse, low byte first
                cur_byte = 8'((~crc_q) >> {cnt_q[1:0], 3'b000});
                tx_en_d  = 1'b1;
                last     = (cnt_q == 11'd3);
            end
            S_IFG: begin
                last   = (cnt_q == IFG_LAST);
                done_d = last;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 11'd0;
            end
        endcase

        if (state_q != S_IDLE && state_q <= S_IFG) begin
            cnt_d = last ? 11'd0 : 11'(cnt_q + 11'd1);
            if (last) begin
                state_d = (state_q == S_IFG) ? S_IDLE : 3'(state_q + 3'd1);
            end
        end

        txd_d       = tx_en_d ? cur_byte : 8'h00;
        busy_d      = (state_q != S_IDLE) || (state_d != S_IDLE);
        frame_cnt_d = frame_cnt_q + {15'd0, done_d};
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 11'd0;
            len_q       <= 11'd0;
            pat_q       <= 11'd0;
            seed_q      <= 8'h00;
            crc_q       <= 32'hFFFF_FFFF;
            txd_q       <= 8'h00;
            tx_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            pat_q       <= pat_d;
            seed_q      <= seed_d;
            crc_q       <= crc_d;
            txd_q       <= txd_d;
            tx_en_q     <= tx_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign gmii_txd   = txd_q;
    assign gmii_tx_en = tx_en_q;
    assign gmii_tx_er = 1'b0;
    assign busy       = busy_q;
    assign done       = done_q;
    assign frame_cnt  = frame_cnt_q;

endmodule
